// File: rtl/lstm_sequencer.sv
// Sample sequencer for the LSTM network layer and its output perceptron.
// Optional watchdog enabled by defining LSTM_SEQ_TIMEOUT_EN.
module lstm_sequencer #(
    parameter int INPUT_SZ       = 2,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int SEQ_LEN        = 8,
    parameter int NET_RST_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int BITWIDTH       = QN + QM + 1,
    localparam int INPUT_BITWIDTH = BITWIDTH * INPUT_SZ
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [INPUT_BITWIDTH-1:0] inVec,
    output logic [INPUT_BITWIDTH-1:0] netInput,
    output logic                      netNewSample,
    output logic                      netReset,
    input  logic                      netDataReady,
    output logic                      percReset,
    input  logic                      percDataReady,
    input  logic [BITWIDTH-1:0]       percOutput,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [BITWIDTH-1:0]       outData,
    output logic                      outLast,
    output logic                      seqErr
);

    localparam logic [2:0] SEQ_RST  = 3'd0;
    localparam logic [2:0] IDLE     = 3'd1;
    localparam logic [2:0] ISSUE    = 3'd2;
    localparam logic [2:0] WAIT_NET = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;
    localparam logic [2:0] PERC_RUN = 3'd5;
    localparam logic [2:0] OUTPUT   = 3'd6;

    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int RST_W = (NET_RST_CYCLES > 1) ? $clog2(NET_RST_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(NET_RST_CYCLES - 1);

    if (SEQ_LEN < 1 || NET_RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : gBadParams
        $error("lstm_sequencer: SEQ_LEN, NET_RST_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    logic [2:0]       state;
    logic [2:0]       stateNext;
    logic [RST_W-1:0] rstCnt;
    logic [IDX_W-1:0] sampleIdx;
    logic             netDrPrev;
    logic             percDrPrev;
    logic             netRise;
    logic             percRise;
    logic             timeout;

`ifdef LSTM_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wdCnt;
`endif

    always_comb begin
        netRise  = netDataReady & ~netDrPrev;
        percRise = percDataReady & ~percDrPrev;
        timeout  = 1'b0;
`ifdef LSTM_SEQ_TIMEOUT_EN
        timeout  = (wdCnt == WD_LAST) &&
                   ((state == WAIT_NET && !netRise) || (state == PERC_RUN && !percRise));
`endif
        stateNext = state;
        case (state)
            SEQ_RST:  if (rstCnt == RST_LAST) stateNext = IDLE;
            IDLE:     if (inValid) stateNext = ISSUE;
            ISSUE:    stateNext = WAIT_NET;
            WAIT_NET: if (netRise) stateNext = GAP;
            GAP:      stateNext = PERC_RUN;
            PERC_RUN: if (percRise) stateNext = OUTPUT;
            OUTPUT:   if (outReady) stateNext = outLast ? SEQ_RST : IDLE;
            default:  stateNext = SEQ_RST;
        endcase
        if (timeout) stateNext = SEQ_RST;
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= SEQ_RST;
            rstCnt       <= '0;
            sampleIdx    <= '0;
            netDrPrev    <= 1'b0;
            percDrPrev   <= 1'b0;
            netInput     <= '0;
            outData      <= '0;
            outLast      <= 1'b0;
            inReady      <= 1'b0;
            netNewSample <= 1'b0;
            netReset     <= 1'b1;
            percReset    <= 1'b1;
            outValid     <= 1'b0;
        end else begin
            state        <= stateNext;
            netDrPrev    <= netDataReady;
            percDrPrev   <= percDataReady;
            inReady      <= (stateNext == IDLE);
            netNewSample <= (stateNext == ISSUE);
            netReset     <= (stateNext == SEQ_RST);
            percReset    <= (stateNext != PERC_RUN);
            outValid     <= (stateNext == OUTPUT);

            if (state == SEQ_RST && stateNext == SEQ_RST) rstCnt <= rstCnt + 1'b1;
            else                                          rstCnt <= '0;

            if (state == SEQ_RST)                           sampleIdx <= '0;
            else if (state == OUTPUT && stateNext == IDLE)  sampleIdx <= sampleIdx + 1'b1;

            if (state == IDLE && stateNext == ISSUE) netInput <= inVec;

            if (state == PERC_RUN && stateNext == OUTPUT) begin
                outData <= percOutput;
                outLast <= (sampleIdx == IDX_LAST);
            end
        end
    end

`ifdef LSTM_SEQ_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wdCnt  <= '0;
            seqErr <= 1'b0;
        end else begin
            if (stateNext != state)                         wdCnt <= '0;
            else if (state == WAIT_NET || state == PERC_RUN) wdCnt <= wdCnt + 1'b1;
            if (timeout) seqErr <= 1'b1;
        end
    end
`else
    assign seqErr = 1'b0;
`endif

endmodule

// File: tb/tb_lstm_sequencer.sv
// Directed bench for lstm_sequencer: reset, single sample, full sequences,
// backpressure, stuck netDataReady, mid-operation reset and the watchdog.
module tb_lstm_sequencer;

    localparam int BW  = 18;
    localparam int IBW = 36;

    logic           clock = 1'b0;
    logic           reset;
    logic           inValid;
    logic           inReady;
    logic [IBW-1:0] inVec;
    logic [IBW-1:0] netInput;
    logic           netNewSample;
    logic           netReset;
    logic           netDataReady;
    logic           percReset;
    logic           percDataReady;
    logic [BW-1:0]  percOutput;
    logic           outValid;
    logic           outReady;
    logic [BW-1:0]  outData;
    logic           outLast;
    logic           seqErr;

    int checks = 0;
    int errors = 0;

    lstm_sequencer #(
        .INPUT_SZ(2), .QN(6), .QM(11), .SEQ_LEN(8),
        .NET_RST_CYCLES(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clock(clock), .reset(reset),
        .inValid(inValid), .inReady(inReady), .inVec(inVec),
        .netInput(netInput), .netNewSample(netNewSample), .netReset(netReset),
        .netDataReady(netDataReady), .percReset(percReset),
        .percDataReady(percDataReady), .percOutput(percOutput),
        .outValid(outValid), .outReady(outReady), .outData(outData),
        .outLast(outLast), .seqErr(seqErr)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts netReset cycles until the sequencer reopens its input.
    task automatic checkSeqRst(input string tag);
        int n = 0;
        while (netReset && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_len"}, n, 4);
        check({tag, "_ready"}, inReady, 1'b1);
    endtask

    task automatic runToOutput(input logic [IBW-1:0] vec, input logic [BW-1:0] pv,
                               input int lat, input bit expLast, input bit holdNet);
        int n = 0;
        inValid = 1'b1;
        inVec   = vec;
        while (!inReady && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", inReady, 1'b1);
        tick();
        inValid = 1'b0;
        inVec   = '1;
        check("new_sample_hi", netNewSample, 1'b1);
        check("net_input", netInput, vec);
        tick();
        check("new_sample_lo", netNewSample, 1'b0);
        if (netDataReady) begin
            repeat (10) tick();
            check("stuck_hold", {percReset, outValid}, 2'b10);
            netDataReady = 1'b0;
            tick();
        end
        repeat (lat - 2) tick();
        netDataReady = 1'b1;
        tick();
        check("perc_rst_gap", percReset, 1'b1);
        tick();
        check("perc_rst_low", percReset, 1'b0);
        if (!holdNet) netDataReady = 1'b0;
        percOutput = pv;
        repeat (3) tick();
        check("perc_wait", {percReset, outValid}, 2'b00);
        percDataReady = 1'b1;
        tick();
        percDataReady = 1'b0;
        percOutput    = ~pv;
        check("out_valid", outValid, 1'b1);
        check("perc_rst_back", percReset, 1'b1);
        check("out_data", outData, pv);
        check("out_last", outLast, expLast);
    endtask

    task automatic finishOutput(input logic [BW-1:0] pv, input bit expLast, input int bp);
        logic stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            tick();
            if (!(outValid && outData == pv && outLast == expLast && !inReady)) stable = 1'b0;
        end
        if (bp > 0) check("bp_stable", stable, 1'b1);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        check("out_xfer", outValid, 1'b0);
        if (expLast) check("seq_rst_entry", netReset, 1'b1);
        else         check("idle_entry", inReady, 1'b1);
    endtask

    task automatic doSample(input logic [IBW-1:0] vec, input logic [BW-1:0] pv, input int lat,
                            input bit expLast, input int bp, input bit holdNet);
        runToOutput(vec, pv, lat, expLast, holdNet);
        finishOutput(pv, expLast, bp);
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; inVec = '0; netDataReady = 1'b0;
        percDataReady = 1'b0; percOutput = '0; outReady = 1'b0;
        repeat (3) tick();
        check("rst_inReady", inReady, 1'b0);
        check("rst_netInput", netInput, '0);
        check("rst_newSample", netNewSample, 1'b0);
        check("rst_netReset", netReset, 1'b1);
        check("rst_percReset", percReset, 1'b1);
        check("rst_outValid", outValid, 1'b0);
        check("rst_outData", outData, '0);
        check("rst_outLast", outLast, 1'b0);
        check("rst_seqErr", seqErr, 1'b0);

        reset = 1'b0;
        checkSeqRst("release");
        check("release_others", {netNewSample, percReset, outValid, outLast, seqErr}, 5'b01000);
        check("release_data", outData, '0);

        // Sequence 1: first sample from the test plan, then backpressure and a stuck netDataReady.
        doSample({18'h00800, 18'h3F800}, 18'h00400, 20, 1'b0, 0, 1'b0);
        for (int i = 1; i < 8; i++)
            doSample({18'(i * 7 + 1), 18'(18'h3FFFF - i)}, 18'(18'h10000 + i), 5 + i,
                     i == 7, (i == 3) ? 10 : 0, i == 4);
        checkSeqRst("seq1_rst");

        for (int s = 2; s <= 3; s++) begin
            for (int i = 0; i < 8; i++)
                doSample({18'(s * 100 + i), 18'(s * 1000 + i * 3)}, 18'(18'h3F000 + s * 16 + i),
                         4 + (i % 3), i == 7, 0, 1'b0);
            checkSeqRst("seqN_rst");
        end

        // Reset while a result is waiting: the result is dropped.
        runToOutput({18'h00123, 18'h00456}, 18'h01111, 6, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check("midrst_outValid", outValid, 1'b0);
        check("midrst_outData", outData, '0);
        check("midrst_netReset", netReset, 1'b1);
        check("midrst_netInput", netInput, '0);
        reset = 1'b0;
        checkSeqRst("midrst_release");
        doSample({18'h00001, 18'h00002}, 18'h00777, 5, 1'b0, 0, 1'b0);

        // Network never answers.
        begin
            int n = 0;
            inValid = 1'b1;
            inVec   = {18'h00aaa, 18'h00555};
            while (!inReady && n < 50) begin
                tick();
                n++;
            end
            tick();
            inValid = 1'b0;
            check("to_new_sample", netNewSample, 1'b1);
`ifdef LSTM_SEQ_TIMEOUT_EN
            n = 0;
            tick();
            while (!netReset && n < 200) begin
                n++;
                check("to_no_output", outValid, 1'b0);
                tick();
            end
            check("to_wait_len", n, 64);
            check("to_seqErr", seqErr, 1'b1);
            checkSeqRst("to_rst");
            check("to_sticky", seqErr, 1'b1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("to_clear", seqErr, 1'b0);
`else
            repeat (100) tick();
            check("nto_state", {netReset, inReady, percReset, outValid}, 4'b0010);
            check("nto_seqErr", seqErr, 1'b0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lstm_sequencer.md
# lstm_sequencer

Hardware sample sequencer that drives the LSTM `network` layer and its `array_prod` output perceptron. It accepts input vectors over a valid/ready stream and runs each sequence of `SEQ_LEN` samples: network reset, `newSample` pulse, wait for `dataReady`, perceptron enable, wait for the perceptron's `dataReady`. It returns one scalar network output per sample on a valid/ready stream. It sits between the host/DMA input path and the result path, and replaces the bench-level sequencing loop in hardware.

## Interface
- `INPUT_SZ`, 2, elements per input vector
- `QN`, 6, integer bits of fixed-point format
- `QM`, 11, fractional bits
- `SEQ_LEN`, 8, samples per sequence (≥1)
- `NET_RST_CYCLES`, 4, cycles `netReset` is held at sequence start (≥1)
- `TIMEOUT_CYCLES`, 1024, watchdog limit (used only with `LSTM_SEQ_TIMEOUT_EN`)
- Derived: `BITWIDTH = QN+QM+1`; `INPUT_BITWIDTH = BITWIDTH*INPUT_SZ`

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `inValid` in 1: input vector valid
- `inReady` out 1: sequencer accepts vector
- `inVec` in INPUT_BITWIDTH: element k at `[k*BITWIDTH +: BITWIDTH]`
- `netInput` out INPUT_BITWIDTH: registered vector to network `inputVec`
- `netNewSample` out 1: to network `newSample`
- `netReset` out 1: to network `reset`
- `netDataReady` in 1: from network `dataReady`
- `percReset` out 1: to perceptron reset (1 = held in reset)
- `percDataReady` in 1: from perceptron `dataReady`
- `percOutput` in BITWIDTH: perceptron result, signed Q(QN.QM)
- `outValid` out 1, `outReady` in 1: result handshake
- `outData` out BITWIDTH: captured result
- `outLast` out 1: marks sample `SEQ_LEN-1` of a sequence
- `seqErr` out 1: sticky watchdog error

## Operation
- FSM states: `SEQ_RST`, `IDLE`, `ISSUE`, `WAIT_NET`, `GAP`, `PERC_RUN`, `OUTPUT`.
- `SEQ_RST`: `netReset=1` for `NET_RST_CYCLES` cycles; clears `sampleIdx`; then `IDLE`.
- `IDLE`: `inReady=1`. When `inValid&&inReady`, latch `inVec` into `netInput` and go to `ISSUE`.
- `ISSUE`: `netNewSample=1` for exactly one cycle, then `WAIT_NET`.
- `WAIT_NET`: waits for a rising edge of `netDataReady` (registered previous value; a held-high level never triggers), then `GAP`.
- `GAP`: one idle cycle, then `PERC_RUN`.
- `PERC_RUN`: `percReset=0`. On a rising edge of `percDataReady`, capture `percOutput` into `outData`, set `outLast = (sampleIdx==SEQ_LEN-1)`, go to `OUTPUT`.
- `OUTPUT`: `percReset=1`, `outValid=1`. On `outReady`, deassert `outValid`. Then:
  - if last sample, go to `SEQ_RST`;
  - otherwise increment `sampleIdx` and go to `IDLE`.
- `sampleIdx` width is `clog2(SEQ_LEN)` (min 1); it wraps to 0 only through `SEQ_RST`.
- `outData` is a bit-exact copy of `percOutput`; no arithmetic.
- `percReset=1` in every state except `PERC_RUN`. `netReset=1` only in `SEQ_RST`.

## Timing
- Reset values: `inReady=0`, `netInput=0`, `netNewSample=0`, `netReset=1`, `percReset=1`, `outValid=0`, `outData=0`, `outLast=0`, `seqErr=0`. The state after reset is `SEQ_RST`.
- All outputs are registered.
- First `inReady=1` occurs `NET_RST_CYCLES` cycles after `reset` deasserts.
- Accept at edge N:
  - `netNewSample` high during cycle N+1 only;
  - `netInput` stable from N+1 until the next accept.
- `netDataReady` rising at edge M: `percReset` low from M+2.
- `percDataReady` rising at edge P: `outValid` high from P+1, and `percReset=1` from P+1.
- Throughput is one sample per network + perceptron latency + ~5 cycles; no overlap between samples.
- `outValid` holds with stable `outData`/`outLast` until `outReady`. `outReady` already high when `outValid` rises means a 1-cycle transfer.
- Reset mid-operation: returns to the reset values and restarts at `SEQ_RST` on the next cycle. A pending output is dropped.
- `SEQ_LEN=1`: every result has `outLast=1`, and `SEQ_RST` runs between all samples.

## Configuration
- `LSTM_SEQ_TIMEOUT_EN` defined:
  - a watchdog counts cycles spent in `WAIT_NET` or `PERC_RUN`;
  - on reaching `TIMEOUT_CYCLES` it sets `seqErr=1` (sticky until `reset`) and goes to `SEQ_RST` without producing output;
  - counter clears on each state entry.
- `LSTM_SEQ_TIMEOUT_EN` undefined: no counter; the sequencer waits indefinitely; `seqErr` is tied to 0.

## Test plan
- Reset release with `NET_RST_CYCLES=4` → `netReset` high exactly 4 cycles after `reset` drops; then `inReady=1`, all other outputs at reset values.
- Single sample: `inVec={18'h00800,18'h3F800}`; network model raises `dataReady` 20 cycles after `newSample`; perceptron returns `18'h00400` → `netNewSample` is one 1-cycle pulse; `percReset` goes low 2 cycles after the edge; `outData=18'h00400`, `outLast=0`.
- Full sequence, `SEQ_LEN=8`, 8 back-to-back vectors → 8 outputs in order, `outLast` only on the 8th, `SEQ_RST` (4 cycles of `netReset`) between sequences; 3 sequences total.
- Backpressure: `outReady=0` for 10 cycles → `outValid`/`outData` stable, `inReady=0` throughout; one transfer when released.
- `netDataReady` stuck high from the previous sample → no advance until it drops and rises again.
- With `LSTM_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES=64`, network never responds → `seqErr=1` after 64 cycles, `netReset` pulses, no `outValid`; without the macro, the FSM remains in `WAIT_NET` and `seqErr=0`.
